// File: rtl/ripple_count_capture.sv
// Synchronous capture of an asynchronous ripple-counter bus with ripple-glitch filtering and step classification.
// Optional `RIPPLE_CAPTURE_ERRCNT_EN adds a saturating err_count output.
module ripple_count_capture #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             cnt_valid,
    output logic             dir_up,
    output logic             step_ok,
    output logic             wrap,
    output logic             err
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam logic [3:0]       RUN_MAX = 4'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [3:0]       run;
    logic             has_ref;

    logic [3:0]       run_nxt;
    logic             commit;
    logic             is_up;
    logic             is_dn;

    function automatic logic [3:0] run_sat_inc(input logic [3:0] r);
        return (r >= RUN_MAX) ? RUN_MAX : r + 4'd1;
    endfunction

    // The filter compares the sample entering the second sync stage with the one leaving it,
    // so stability counting overlaps synchronisation and costs no extra cycle.
    always_comb begin
        run_nxt = (sync_p0 == sync_p1) ? run_sat_inc(run) : 4'd0;
        commit  = (run_nxt == RUN_MAX) && ((sync_p1 != cnt_out) || !has_ref);
        is_up   = (sync_p1 == cnt_out + ONE);
        is_dn   = (sync_p1 == cnt_out - ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            run       <= 4'd0;
            has_ref   <= 1'b0;
            cnt_out   <= '0;
            cnt_valid <= 1'b0;
            dir_up    <= 1'b1;
            step_ok   <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // sync stage boundary: p0 -> p1 -> commit
            sync_p0   <= cnt_in;
            sync_p1   <= sync_p0;
            run       <= run_nxt;
            cnt_valid <= commit;
            step_ok   <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            if (commit) begin
                cnt_out <= sync_p1;
                has_ref <= 1'b1;
                if (has_ref) begin
                    if (is_up) begin
                        step_ok <= 1'b1;
                        dir_up  <= 1'b1;
                        wrap    <= &cnt_out;
                    end else if (is_dn) begin
                        step_ok <= 1'b1;
                        dir_up  <= 1'b0;
                        wrap    <= ~|cnt_out;
                    end else begin
                        err     <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RIPPLE_CAPTURE_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture (WIDTH=4, STABLE_CYCLES=2).
module tb_ripple_count_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic [3:0] cnt_out;
    logic       cnt_valid, dir_up, step_ok, wrap, err;
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    ripple_count_capture #(.WIDTH(4), .STABLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .dir_up    (dir_up),
        .step_ok   (step_ok),
        .wrap      (wrap),
        .err       (err)
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Holds v on cnt_in for n edges; reports commit count and the flags of the last commit.
    task automatic drive_hold(input logic [3:0] v, input int n, output int pulses,
                              output logic [3:0] q, output logic ok, output logic up,
                              output logic wr, output logic er);
        cnt_in = v;
        pulses = 0; q = 4'h0; ok = 1'b0; up = 1'b0; wr = 1'b0; er = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (cnt_valid) begin
                pulses++;
                q = cnt_out; ok = step_ok; up = dir_up; wr = wrap; er = err;
            end
        end
    endtask

    task automatic test_reset();
        int first_edge;
        int pulses;
        logic [3:0] q; logic ok, up, wr, er;
        rst_n = 1'b0;
        cnt_in = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cnt_out, cnt_valid, dir_up, step_ok, wrap, err} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b want %b", {cnt_out, cnt_valid, dir_up, step_ok, wrap, err}, 9'b0000_01000);
        end
        rst_n = 1'b1;
        first_edge = 0;
        for (int i = 1; i <= 12 && first_edge == 0; i++) begin
            @(posedge clk); #1;
            if (cnt_valid) begin
                first_edge = i;
                q = cnt_out; ok = step_ok; er = err;
            end
        end
        checks++;
        if (first_edge !== 4) begin
            errors++;
            $display("FAIL first_commit_latency got %0d want 4", first_edge);
        end
        checks++;
        if ({q, ok, er} !== {4'h5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL first_commit got q=%0h ok=%b err=%b want q=5 ok=0 err=0", q, ok, er);
        end
        drive_hold(4'h5, 12, pulses, q, ok, up, wr, er);
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL held_no_recommit got %0d want 0", pulses);
        end
    endtask

    task automatic test_up_count();
        int pulses;
        logic [3:0] q; logic ok, up, wr, er;
        logic [3:0] v;
        v = 4'h5;
        for (int i = 0; i < 11; i++) begin
            v = v + 4'h1;
            drive_hold(v, 8, pulses, q, ok, up, wr, er);
            checks++;
            if (pulses !== 1) begin
                errors++;
                $display("FAIL up_pulses v=%0h got %0d want 1", v, pulses);
            end
            checks++;
            if ({q, ok, up, wr, er} !== {v, 1'b1, 1'b1, (v == 4'h0), 1'b0}) begin
                errors++;
                $display("FAIL up_step v=%0h got q=%0h ok=%b up=%b wrap=%b err=%b", v, q, ok, up, wr, er);
            end
        end
    endtask

    task automatic test_down_count();
        int pulses;
        logic [3:0] q; logic ok, up, wr, er;
        logic [3:0] seq [3];
        seq[0] = 4'h1; seq[1] = 4'h0; seq[2] = 4'hF;
        drive_hold(4'h1, 8, pulses, q, ok, up, wr, er);
        drive_hold(4'h2, 8, pulses, q, ok, up, wr, er);
        for (int i = 0; i < 3; i++) begin
            drive_hold(seq[i], 8, pulses, q, ok, up, wr, er);
            checks++;
            if ({pulses == 1, q, ok, up, wr, er} !== {1'b1, seq[i], 1'b1, 1'b0, (seq[i] == 4'hF), 1'b0}) begin
                errors++;
                $display("FAIL down_step v=%0h got n=%0d q=%0h ok=%b up=%b wrap=%b err=%b",
                         seq[i], pulses, q, ok, up, wr, er);
            end
        end
    endtask

    task automatic test_glitch();
        int pulses, total;
        logic [3:0] q; logic ok, up, wr, er;
        drive_hold(4'h7, 8, pulses, q, ok, up, wr, er);
        total = 0;
        drive_hold(4'h6, 1, pulses, q, ok, up, wr, er); total += pulses;
        drive_hold(4'h4, 1, pulses, q, ok, up, wr, er); total += pulses;
        drive_hold(4'h0, 1, pulses, q, ok, up, wr, er); total += pulses;
        drive_hold(4'h8, 8, pulses, q, ok, up, wr, er); total += pulses;
        checks++;
        if (total !== 1) begin
            errors++;
            $display("FAIL glitch_pulses got %0d want 1", total);
        end
        checks++;
        if ({q, ok, up, er} !== {4'h8, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL glitch_commit got q=%0h ok=%b up=%b err=%b want q=8 ok=1 up=1 err=0", q, ok, up, er);
        end
    endtask

    task automatic test_jump();
        int pulses;
        logic [3:0] q; logic ok, up, wr, er;
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
        logic [7:0] before;
`endif
        drive_hold(4'h7, 8, pulses, q, ok, up, wr, er);
        checks++;
        if ({q, ok, up} !== {4'h7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL jump_setup_down got q=%0h ok=%b up=%b want q=7 ok=1 up=0", q, ok, up);
        end
        drive_hold(4'h3, 8, pulses, q, ok, up, wr, er);
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
        before = err_count;
`endif
        drive_hold(4'h9, 8, pulses, q, ok, up, wr, er);
        checks++;
        if ({pulses == 1, q, ok, up, wr, er} !== {1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL jump_3_to_9 got n=%0d q=%0h ok=%b up=%b wrap=%b err=%b want n=1 q=9 ok=0 up=0 wrap=0 err=1",
                     pulses, q, ok, up, wr, er);
        end
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
        checks++;
        if (err_count !== before + 8'd1) begin
            errors++;
            $display("FAIL err_count_inc got %0d want %0d", err_count, before + 8'd1);
        end
        for (int i = 0; i < 300; i++)
            drive_hold((i % 2 == 0) ? 4'h1 : 4'h9, 5, pulses, q, ok, up, wr, er);
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_count_sat got %0d want 255", err_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [3:0] q; logic ok, up, wr, er;
        drive_hold(4'h9, 8, pulses, q, ok, up, wr, er);
        drive_hold(4'hA, 8, pulses, q, ok, up, wr, er);
        checks++;
        if ({cnt_out, dir_up} !== {4'hA, 1'b1}) begin
            errors++;
            $display("FAIL mid_setup got q=%0h up=%b want q=a up=1", cnt_out, dir_up);
        end
        drive_hold(4'h9, 8, pulses, q, ok, up, wr, er);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_out, cnt_valid, dir_up, step_ok, wrap, err} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %b want %b", {cnt_out, cnt_valid, dir_up, step_ok, wrap, err}, 9'b0000_01000);
        end
`ifdef RIPPLE_CAPTURE_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_errcnt got %0d want 0", err_count);
        end
`endif
        @(posedge clk); #1;
        cnt_in = 4'h3;
        rst_n = 1'b1;
        drive_hold(4'h3, 8, pulses, q, ok, up, wr, er);
        checks++;
        if ({pulses == 1, q, ok, up, er} !== {1'b1, 4'h3, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_commit got n=%0d q=%0h ok=%b up=%b err=%b want n=1 q=3 ok=0 up=1 err=0",
                     pulses, q, ok, up, er);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cnt_in = 4'h0;
        @(posedge clk); #1;
        test_reset();
        test_up_count();
        test_down_count();
        test_glitch();
        test_jump();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
